// File: rtl/inst_rom_loader.sv
// Instruction RAM with a byte-serial boot loader; holds the core in reset
// until a complete program has been streamed in, then serves fetches combinationally.
module inst_rom_loader #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en_rom,
  input  logic [31:0]       rom_addr,
  output logic [DATA_W-1:0] rom_data,
  input  logic              load_start,
  input  logic              load_valid,
  input  logic [7:0]        load_byte,
  input  logic              load_last,
  output logic              load_ready,
  output logic              cpu_hold,
  output logic              load_done,
  output logic              load_err,
  output logic [ADDR_W:0]   word_cnt
);

  typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

  state_t              state_q, state_d;
  logic [1:0]          k_q, k_d;
  logic [DATA_W-1:0]   word_q, word_d;
  logic [ADDR_W:0]     ptr_q, ptr_d;
  logic                err_q, err_d;
  logic                wr_en;
  logic [4:0]          sh;
  logic [DATA_W-1:0]   merged;
  logic [DATA_W-1:0]   mem_q [2**ADDR_W];
  logic                unused_addr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      k_q     <= 2'd0;
      word_q  <= '0;
      ptr_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      word_q  <= word_d;
      ptr_q   <= ptr_d;
      err_q   <= err_d;
    end
  end

  // Bytes land big-endian; word_q is zero below the current byte, so merged is already padded.
  always_comb begin
    sh         = 5'd24 - {k_q, 3'b000};
    merged     = word_q | (DATA_W'(load_byte) << sh);
    state_d    = state_q;
    k_d        = k_q;
    word_d     = word_q;
    ptr_d      = ptr_q;
    err_d      = err_q;
    wr_en      = 1'b0;
    load_ready = 1'b0;
    cpu_hold   = 1'b1;

    case (state_q)
      LOAD:    load_ready = 1'b1;
      RUN:     cpu_hold   = 1'b0;
      default: ;
    endcase

    if (load_start) begin
      state_d = LOAD;
      k_d     = 2'd0;
      word_d  = '0;
      ptr_d   = '0;
      err_d   = 1'b0;
    end else if (state_q == LOAD && load_valid) begin
      if (k_q == 2'd3 || load_last) begin
        k_d    = 2'd0;
        word_d = '0;
        // Top pointer bit set means the RAM is full: drop the word, saturate.
        if (ptr_q[ADDR_W]) begin
          err_d = 1'b1;
        end else begin
          wr_en = 1'b1;
          ptr_d = ptr_q + 1'b1;
        end
        if (load_last) state_d = RUN;
      end else begin
        k_d    = k_q + 2'd1;
        word_d = merged;
      end
    end else if (state_q != IDLE && state_q != LOAD && state_q != RUN) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[ptr_q[ADDR_W-1:0]] <= merged;
  end

  // Zero-latency read: the core's decode stage samples rom_data on the same edge as pc.
  assign rom_data    = (en_rom && !cpu_hold) ? mem_q[rom_addr[ADDR_W+1:2]] : '0;
  assign unused_addr = ^{rom_addr[31:ADDR_W+2], rom_addr[1:0]};

  assign load_done = (state_q == RUN);
  assign load_err  = err_q;
  assign word_cnt  = ptr_q;

endmodule

// File: tb/tb_inst_rom_loader.sv
// Bench for inst_rom_loader: a 1024-word and a 4-word instance share one stimulus
// stream and are compared every cycle against a byte-list model.
module tb_inst_rom_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en_rom = 1'b1;
  logic [31:0] rom_addr = '0;
  logic        load_start = 1'b0, load_valid = 1'b0, load_last = 1'b0;
  logic [7:0]  load_byte = '0;

  logic [31:0] rd0, rd1;
  logic        rdy0, rdy1, h0, h1, d0, d1, e0, e1;
  logic [10:0] wc0;
  logic [2:0]  wc1;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  inst_rom_loader #(.ADDR_W(10), .DATA_W(32)) dut (
    .clk(clk), .rst(rst), .en_rom(en_rom), .rom_addr(rom_addr), .rom_data(rd0),
    .load_start(load_start), .load_valid(load_valid), .load_byte(load_byte),
    .load_last(load_last), .load_ready(rdy0), .cpu_hold(h0), .load_done(d0),
    .load_err(e0), .word_cnt(wc0));

  inst_rom_loader #(.ADDR_W(2), .DATA_W(32)) dut_s (
    .clk(clk), .rst(rst), .en_rom(en_rom), .rom_addr(rom_addr), .rom_data(rd1),
    .load_start(load_start), .load_valid(load_valid), .load_byte(load_byte),
    .load_last(load_last), .load_ready(rdy1), .cpu_hold(h1), .load_done(d1),
    .load_err(e1), .word_cnt(wc1));

  // Model: mode 0 idle, 1 loading, 2 running; bytes of the open word kept as a list.
  int          depth [2] = '{1024, 4};
  int          mmode [2];
  int          mptr  [2];
  bit          merr  [2];
  int          mn    [2];
  logic [7:0]  mb    [2][4];
  logic [31:0] mmem  [2][1024];
  bit          mval  [2][1024];
  logic [31:0] mw;

  always @(posedge clk or posedge rst) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        mmode[i] = 0; mptr[i] = 0; merr[i] = 1'b0; mn[i] = 0;
      end else if (load_start) begin
        mmode[i] = 1; mptr[i] = 0; merr[i] = 1'b0; mn[i] = 0;
      end else if (mmode[i] == 1 && load_valid) begin
        mb[i][mn[i]] = load_byte;
        mn[i]++;
        if (mn[i] == 4 || load_last) begin
          mw = '0;
          for (int j = 0; j < mn[i]; j++) mw[31-8*j -: 8] = mb[i][j];
          if (mptr[i] < depth[i]) begin
            mmem[i][mptr[i]] = mw;
            mval[i][mptr[i]] = 1'b1;
            mptr[i]++;
          end else begin
            merr[i] = 1'b1;
          end
          mn[i] = 0;
          if (load_last) mmode[i] = 2;
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_inst(input int i, input logic h, input logic r, input logic d,
                            input logic e, input logic [31:0] wc, input logic [31:0] rd);
    int idx;
    idx = int'(rom_addr[11:2]) % depth[i];
    chk($sformatf("cpu_hold[%0d]", i),   32'(h),  32'(mmode[i] != 2));
    chk($sformatf("load_ready[%0d]", i), 32'(r),  32'(mmode[i] == 1));
    chk($sformatf("load_done[%0d]", i),  32'(d),  32'(mmode[i] == 2));
    chk($sformatf("load_err[%0d]", i),   32'(e),  32'(merr[i]));
    chk($sformatf("word_cnt[%0d]", i),   wc,      32'(mptr[i]));
    if (!(en_rom && mmode[i] == 2))
      chk($sformatf("rom_data_off[%0d]", i), rd, 32'h0);
    else if (mval[i][idx])
      chk($sformatf("rom_data[%0d]", i), rd, mmem[i][idx]);
  endtask

  always @(negedge clk) begin
    check_inst(0, h0, rdy0, d0, e0, 32'(wc0), rd0);
    check_inst(1, h1, rdy1, d1, e1, 32'(wc1), rd1);
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic start_load();
    load_start = 1'b1;
    cyc();
    load_start = 1'b0;
  endtask

  task automatic send(input logic [7:0] b, input logic last);
    load_valid = 1'b1;
    load_byte  = b;
    load_last  = last;
    cyc();
    load_valid = 1'b0;
    load_last  = 1'b0;
  endtask

  task automatic peek(input string nm, input logic [31:0] addr,
                      input logic [31:0] exp0, input logic [31:0] exp1);
    rom_addr = addr;
    #1;
    chk({nm, "_big"}, rd0, exp0);
    chk({nm, "_small"}, rd1, exp1);
  endtask

  initial begin
    #2;
    chk("reset_hold", 32'(h0), 32'h1);
    chk("reset_ready", 32'(rdy0), 32'h0);
    chk("reset_done", 32'(d0), 32'h0);
    chk("reset_cnt", 32'(wc0), 32'h0);
    chk("reset_rd", rd0, 32'h0);
    cyc(); cyc();
    rst = 1'b0;

    // Single word program.
    start_load();
    chk("loading_ready", 32'(rdy0), 32'h1);
    send(8'h24, 1'b0); send(8'h01, 1'b0); send(8'h00, 1'b0); send(8'h05, 1'b1);
    chk("t1_hold", 32'(h0), 32'h0);
    chk("t1_done", 32'(d0), 32'h1);
    chk("t1_cnt", 32'(wc0), 32'h1);
    peek("t1_rd", 32'h0, 32'h24010005, 32'h24010005);

    // Six bytes, second word zero-padded.
    start_load();
    send(8'hAA, 1'b0); send(8'hBB, 1'b0); send(8'hCC, 1'b0); send(8'hDD, 1'b0);
    send(8'h11, 1'b0); send(8'h22, 1'b1);
    chk("t2_cnt", 32'(wc0), 32'h2);
    peek("t2_w0", 32'h0, 32'hAABBCCDD, 32'hAABBCCDD);
    peek("t2_w1", 32'h4, 32'h11220000, 32'h11220000);
    peek("t2_addr7", 32'h7, 32'h11220000, 32'h11220000);
    en_rom = 1'b0;
    #1;
    chk("t2_en_off", rd0, 32'h0);
    en_rom = 1'b1;
    rom_addr = '0;

    // Valid toggling; stall cycles carry junk data with last set.
    start_load();
    foreach (mb[0][j]) begin end
    for (int j = 0; j < 8; j++) begin
      logic [7:0] seq [8];
      seq = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h11, 8'h22, 8'h33, 8'h44};
      send(seq[j], j == 7);
      if (j != 7) begin
        load_byte = 8'hFF;
        load_last = 1'b1;
        cyc();
        load_last = 1'b0;
      end
    end
    chk("t3_cnt", 32'(wc0), 32'h2);
    peek("t3_w0", 32'h0, 32'hAABBCCDD, 32'hAABBCCDD);
    peek("t3_w1", 32'h4, 32'h11223344, 32'h11223344);
    rom_addr = '0;

    // Five words: the 4-word instance overflows and must not wrap.
    start_load();
    for (int j = 1; j <= 20; j++) send(8'(j), j == 20);
    chk("t4_err_small", 32'(e1), 32'h1);
    chk("t4_cnt_small", 32'(wc1), 32'h4);
    chk("t4_err_big", 32'(e0), 32'h0);
    chk("t4_cnt_big", 32'(wc0), 32'h5);
    peek("t4_w0", 32'h0, 32'h01020304, 32'h01020304);
    peek("t4_w3", 32'hC, 32'h0D0E0F10, 32'h0D0E0F10);
    peek("t4_alias", 32'h10, 32'h11121314, 32'h01020304);
    rom_addr = '0;

    // Restart mid-load; the byte arriving with the restart is dropped.
    start_load();
    send(8'h77, 1'b0); send(8'h66, 1'b0);
    load_start = 1'b1; load_valid = 1'b1; load_byte = 8'h55; load_last = 1'b1;
    cyc();
    load_start = 1'b0; load_valid = 1'b0; load_last = 1'b0;
    chk("t5_still_loading", 32'(h0), 32'h1);
    send(8'h0A, 1'b0); send(8'h0B, 1'b0); send(8'h0C, 1'b0); send(8'h0D, 1'b1);
    chk("t5_cnt", 32'(wc0), 32'h1);
    chk("t5_err_clr", 32'(e1), 32'h0);
    peek("t5_w0", 32'h0, 32'h0A0B0C0D, 32'h0A0B0C0D);

    // New load from RUN, then asynchronous reset after two bytes.
    start_load();
    chk("t6_hold", 32'(h0), 32'h1);
    chk("t6_cnt", 32'(wc0), 32'h0);
    send(8'h99, 1'b0); send(8'h88, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    chk("t6_rst_hold", 32'(h0), 32'h1);
    chk("t6_rst_ready", 32'(rdy0), 32'h0);
    chk("t6_rst_done", 32'(d0), 32'h0);
    chk("t6_rst_rd", rd0, 32'h0);
    cyc();
    rst = 1'b0;
    cyc(); cyc();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
